// File: rtl/rv2t_fetch_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
//   XLEN         data word width returned to the fetch unit
//   PC_BITWIDTH  byte-address width of fetch requests
//   WAIT_CNT_W   width of the wait-state counter (WAIT_STATES is 0..15)
//   resp_state_e one-hot responder FSM encoding (S_IDLE, S_WAIT)
package rv2t_fetch_mem_responder_pkg;

    localparam int XLEN        = 32;
    localparam int PC_BITWIDTH = 32;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_WAIT = 2'b10
    } resp_state_e;

    // A fetch address is misaligned when either byte-offset bit is set.
    function automatic logic addr_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/rv2t_wait_state_counter.sv
// Wait-state down-counter for the fetch responder.
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous clear back to zero
//   load          load load_val (takes priority over dec)
//   load_val      number of cycles the access stays in S_WAIT
//   dec           decrement by one (saturates at zero)
//   terminal      high while the count equals one: last wait cycle
module rv2t_wait_state_counter
    import rv2t_fetch_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  terminal
);

    logic [WAIT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign terminal = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/rv2t_fetch_mem_responder.sv
// Memory-side responder for the instruction-fetch read port. Turns single-cycle
// read strobes into SRAM reads, adds WAIT_STATES extra cycles per access and
// keeps one pending request so a fetch restart issued mid-access is not lost.
//   clk, reset_n     clock, asynchronous active-low reset
//   sync_reset       synchronous active-high reset (abandons any access)
//   read_mem_enable  request strobe, read_mem_addr is the byte address
//   mem_read_done    one-cycle pulse, mem_data valid
//   mem_data         read word (live SRAM data in the done cycle, then held)
//   mem_busy         access in S_WAIT or pending slot occupied
//   misaligned_err   pulses with mem_read_done for addr[1:0] != 0
//   pending_overrun  pulses when an occupied pending slot is overwritten
//   sram_re/sram_addr/sram_rdata  single-port synchronous SRAM, 1-cycle read
//   state_dbg        current FSM state
//
// Handshake: there is no ready. Every cycle with read_mem_enable high is one
// request and is always accepted: issued at once when idle, otherwise parked
// in the pending slot (newest wins). Each issued request produces exactly one
// mem_read_done; mem_busy is informational only.
module rv2t_fetch_mem_responder
    import rv2t_fetch_mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int SRAM_AW     = PC_BITWIDTH - 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   read_mem_enable,
    input  logic [PC_BITWIDTH-1:0] read_mem_addr,
    output logic                   mem_read_done,
    output logic [XLEN-1:0]        mem_data,
    output logic                   mem_busy,
    output logic                   misaligned_err,
    output logic                   pending_overrun,
    output logic                   sram_re,
    output logic [SRAM_AW-1:0]     sram_addr,
    input  logic [XLEN-1:0]        sram_rdata,
    output resp_state_e            state_dbg
);

    resp_state_e        state_q, state_d;
    logic [SRAM_AW-1:0] addr_q;
    logic               mis_q;
    logic               pend_valid_q;
    logic [SRAM_AW-1:0] pend_addr_q;
    logic               pend_mis_q;
    logic               done_q;
    logic               done_mis_q;
    logic [XLEN-1:0]    data_q;

    logic               req;
    logic [SRAM_AW-1:0] req_word;
    logic               req_mis;

    logic               issue;
    logic [SRAM_AW-1:0] iss_addr;
    logic               iss_mis;
    logic               arm_done;
    logic               arm_mis;
    logic               pend_write;
    logic               pend_clear;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_terminal;

    // A request seen in the same cycle as sync_reset is discarded with everything else.
    assign req      = read_mem_enable & ~sync_reset;
    assign req_word = read_mem_addr[SRAM_AW+1:2];
    assign req_mis  = addr_misaligned(read_mem_addr[1:0]);

    rv2t_wait_state_counter u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (sync_reset),
        .load     (cnt_load),
        .load_val (WAIT_CNT_W'(WAIT_STATES)),
        .dec      (cnt_dec),
        .terminal (cnt_terminal)
    );

    always_comb begin
        state_d         = state_q;
        issue           = 1'b0;
        iss_addr        = addr_q;
        iss_mis         = 1'b0;
        sram_re         = 1'b0;
        sram_addr       = addr_q;
        arm_done        = 1'b0;
        arm_mis         = 1'b0;
        pend_write      = 1'b0;
        pend_clear      = 1'b0;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
        pending_overrun = 1'b0;

        if (!sync_reset) begin
            unique case (state_q)
                S_IDLE: begin
                    // A parked request always goes before a new strobe.
                    if (pend_valid_q) begin
                        issue      = 1'b1;
                        iss_addr   = pend_addr_q;
                        iss_mis    = pend_mis_q;
                        pend_clear = 1'b1;
                    end else if (req) begin
                        issue    = 1'b1;
                        iss_addr = req_word;
                        iss_mis  = req_mis;
                    end
                    if (issue) begin
                        sram_re   = 1'b1;
                        sram_addr = iss_addr;
                        if (WAIT_STATES == 0) begin
                            arm_done = 1'b1;
                            arm_mis  = iss_mis;
                        end else begin
                            state_d  = S_WAIT;
                            cnt_load = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    sram_re   = 1'b1;
                    sram_addr = addr_q;
                    cnt_dec   = 1'b1;
                    if (cnt_terminal) begin
                        arm_done = 1'b1;
                        arm_mis  = mis_q;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Any strobe not issued directly lands in the pending slot, including
            // one that coincides with the pending request leaving the slot.
            if (req && !((state_q == S_IDLE) && !pend_valid_q)) begin
                pend_write      = 1'b1;
                pending_overrun = pend_valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            mis_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_mis_q   <= 1'b0;
            done_q       <= 1'b0;
            done_mis_q   <= 1'b0;
            data_q       <= '0;
        end else if (sync_reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            mis_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_mis_q   <= 1'b0;
            done_q       <= 1'b0;
            done_mis_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= arm_done;
            done_mis_q <= arm_mis;
            if (issue) begin
                addr_q <= iss_addr;
                mis_q  <= iss_mis;
            end
            // SRAM data is only valid in the done cycle; keep it for later readers.
            if (done_q) begin
                data_q <= sram_rdata;
            end
            if (pend_write) begin
                pend_valid_q <= 1'b1;
                pend_addr_q  <= req_word;
                pend_mis_q   <= req_mis;
            end else if (pend_clear) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign mem_read_done  = done_q;
    assign mem_data       = done_q ? sram_rdata : data_q;
    assign misaligned_err = done_mis_q;
    assign mem_busy       = (state_q == S_WAIT) | pend_valid_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_rv2t_fetch_mem_responder.sv
module tb_rv2t_fetch_mem_responder;
    import rv2t_fetch_mem_responder_pkg::*;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sync_reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with WAIT_STATES=0 ----------------
    logic        en0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic        done0, busy0, mis0, ovr0, re0;
    logic [31:0] data0;
    logic [31:0] rdata0 = '0;
    logic [29:0] saddr0;
    resp_state_e st0;

    rv2t_fetch_mem_responder #(.WAIT_STATES(0)) u0 (
        .clk             (clk),
        .reset_n         (reset_n),
        .sync_reset      (sync_reset),
        .read_mem_enable (en0),
        .read_mem_addr   (addr0),
        .mem_read_done   (done0),
        .mem_data        (data0),
        .mem_busy        (busy0),
        .misaligned_err  (mis0),
        .pending_overrun (ovr0),
        .sram_re         (re0),
        .sram_addr       (saddr0),
        .sram_rdata      (rdata0),
        .state_dbg       (st0)
    );

    // ---------------- DUT with WAIT_STATES=3 ----------------
    logic        en3 = 1'b0;
    logic [31:0] addr3 = '0;
    logic        done3, busy3, mis3, ovr3, re3;
    logic [31:0] data3;
    logic [31:0] rdata3 = '0;
    logic [29:0] saddr3;
    resp_state_e st3;

    rv2t_fetch_mem_responder #(.WAIT_STATES(3)) u3 (
        .clk             (clk),
        .reset_n         (reset_n),
        .sync_reset      (sync_reset),
        .read_mem_enable (en3),
        .read_mem_addr   (addr3),
        .mem_read_done   (done3),
        .mem_data        (data3),
        .mem_busy        (busy3),
        .misaligned_err  (mis3),
        .pending_overrun (ovr3),
        .sram_re         (re3),
        .sram_addr       (saddr3),
        .sram_rdata      (rdata3),
        .state_dbg       (st3)
    );

    // ---------------- SRAM stubs ----------------
    // Word 0x40 holds 0x00000013; every other word reads as 0x80000000 | word_addr.
    function automatic logic [31:0] sram_word(input logic [29:0] a);
        if (a == 30'h40) return 32'h0000_0013;
        return {2'b10, a};
    endfunction

    always @(posedge clk) if (re0) rdata0 <= sram_word(saddr0);
    always @(posedge clk) if (re3) rdata3 <= sram_word(saddr3);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and clear strobes; the caller
    // then sets this cycle's inputs and waits #1 before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
        en0 = 1'b0;
        en3 = 1'b0;
        sync_reset = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values while reset_n is low
        #12;
        chk("rst_done0", {31'b0, done0}, 32'h0);
        chk("rst_data0", data0, 32'h0);
        chk("rst_busy0", {31'b0, busy0}, 32'h0);
        chk("rst_re0",   {31'b0, re0}, 32'h0);
        chk("rst_saddr0", {2'b0, saddr0}, 32'h0);
        chk("rst_done3", {31'b0, done3}, 32'h0);
        chk("rst_mis3",  {31'b0, mis3}, 32'h0);
        chk("rst_ovr3",  {31'b0, ovr3}, 32'h0);
        chk("rst_re3",   {31'b0, re3}, 32'h0);
        chk("rst_state3", {30'b0, st3}, {30'b0, S_IDLE});
        reset_n = 1'b1;

        // 1: single request, WAIT_STATES=0
        cyc(); en0 = 1'b1; addr0 = 32'h100; #1;
        chk("t1_re", {31'b0, re0}, 32'h1);
        chk("t1_saddr", {2'b0, saddr0}, 32'h40);
        chk("t1_nodone", {31'b0, done0}, 32'h0);
        cyc(); #1;
        chk("t1_done", {31'b0, done0}, 32'h1);
        chk("t1_data", data0, 32'h0000_0013);
        chk("t1_mis", {31'b0, mis0}, 32'h0);
        cyc(); #1;
        chk("t1_done_end", {31'b0, done0}, 32'h0);
        chk("t1_data_hold", data0, 32'h0000_0013);

        // 2: back-to-back requests, no bubbles, never busy
        cyc(); en0 = 1'b1; addr0 = 32'h0; #1;
        chk("t2_busy_a", {31'b0, busy0}, 32'h0);
        cyc(); en0 = 1'b1; addr0 = 32'h4; #1;
        chk("t2_done_a", {31'b0, done0}, 32'h1);
        chk("t2_data_a", data0, 32'h8000_0000);
        chk("t2_busy_b", {31'b0, busy0}, 32'h0);
        cyc(); en0 = 1'b1; addr0 = 32'h8; #1;
        chk("t2_done_b", {31'b0, done0}, 32'h1);
        chk("t2_data_b", data0, 32'h8000_0001);
        chk("t2_busy_c", {31'b0, busy0}, 32'h0);
        cyc(); #1;
        chk("t2_done_c", {31'b0, done0}, 32'h1);
        chk("t2_data_c", data0, 32'h8000_0002);
        chk("t2_busy_d", {31'b0, busy0}, 32'h0);
        cyc(); #1;
        chk("t2_idle", {31'b0, done0}, 32'h0);

        // 5: misaligned request
        cyc(); en0 = 1'b1; addr0 = 32'h102; #1;
        chk("t5_saddr", {2'b0, saddr0}, 32'h40);
        cyc(); #1;
        chk("t5_done", {31'b0, done0}, 32'h1);
        chk("t5_mis", {31'b0, mis0}, 32'h1);
        chk("t5_data", data0, 32'h0000_0013);
        cyc(); #1;
        chk("t5_mis_end", {31'b0, mis0}, 32'h0);

        // 3: WAIT_STATES=3 with a pending request
        cyc(); en3 = 1'b1; addr3 = 32'h20; #1;                     // T
        chk("t3_re_T", {31'b0, re3}, 32'h1);
        chk("t3_saddr_T", {2'b0, saddr3}, 32'h8);
        chk("t3_busy_T", {31'b0, busy3}, 32'h0);
        cyc(); en3 = 1'b1; addr3 = 32'h40; #1;                     // T+1
        chk("t3_re_T1", {31'b0, re3}, 32'h1);
        chk("t3_saddr_T1", {2'b0, saddr3}, 32'h8);
        chk("t3_busy_T1", {31'b0, busy3}, 32'h1);
        chk("t3_ovr_T1", {31'b0, ovr3}, 32'h0);
        chk("t3_state_T1", {30'b0, st3}, {30'b0, S_WAIT});
        cyc(); #1;                                                  // T+2
        chk("t3_re_T2", {31'b0, re3}, 32'h1);
        chk("t3_done_T2", {31'b0, done3}, 32'h0);
        cyc(); #1;                                                  // T+3
        chk("t3_re_T3", {31'b0, re3}, 32'h1);
        chk("t3_saddr_T3", {2'b0, saddr3}, 32'h8);
        chk("t3_done_T3", {31'b0, done3}, 32'h0);
        cyc(); #1;                                                  // T+4
        chk("t3_done_T4", {31'b0, done3}, 32'h1);
        chk("t3_data_T4", data3, 32'h8000_0008);
        chk("t3_re_T4", {31'b0, re3}, 32'h1);
        chk("t3_saddr_T4", {2'b0, saddr3}, 32'h10);
        chk("t3_busy_T4", {31'b0, busy3}, 32'h1);
        cyc(); #1;                                                  // T+5
        chk("t3_done_T5", {31'b0, done3}, 32'h0);
        chk("t3_busy_T5", {31'b0, busy3}, 32'h1);
        cyc(); #1;                                                  // T+6
        chk("t3_done_T6", {31'b0, done3}, 32'h0);
        cyc(); #1;                                                  // T+7
        chk("t3_done_T7", {31'b0, done3}, 32'h0);
        chk("t3_re_T7", {31'b0, re3}, 32'h1);
        cyc(); #1;                                                  // T+8
        chk("t3_done_T8", {31'b0, done3}, 32'h1);
        chk("t3_data_T8", data3, 32'h8000_0010);
        chk("t3_re_T8", {31'b0, re3}, 32'h0);
        chk("t3_busy_T8", {31'b0, busy3}, 32'h0);
        cyc(); #1;
        chk("t3_done_T9", {31'b0, done3}, 32'h0);
        chk("t3_data_hold", data3, 32'h8000_0010);

        // 4: overwrite of the pending slot, only the newest request served
        cyc(); en3 = 1'b1; addr3 = 32'h0; #1;                      // T
        cyc(); en3 = 1'b1; addr3 = 32'h40; #1;                     // T+1
        chk("t4_ovr_T1", {31'b0, ovr3}, 32'h0);
        cyc(); en3 = 1'b1; addr3 = 32'h80; #1;                     // T+2
        chk("t4_ovr_T2", {31'b0, ovr3}, 32'h1);
        begin
            int ndone = 0;
            for (int c = 3; c <= 14; c++) begin
                cyc(); #1;
                chk("t4_done_seq", {31'b0, done3}, ((c == 4) || (c == 8)) ? 32'h1 : 32'h0);
                if (c == 3) chk("t4_ovr_T3", {31'b0, ovr3}, 32'h0);
                if (c == 4) chk("t4_data_first", data3, 32'h8000_0000);
                if (c == 8) chk("t4_data_second", data3, 32'h8000_0020);
                if (done3) ndone++;
            end
            chk("t4_done_count", ndone, 32'd2);
        end

        // 6: sync_reset in the middle of S_WAIT
        cyc(); en3 = 1'b1; addr3 = 32'h100; #1;                    // T
        cyc(); #1;                                                  // T+1
        chk("t6_state_T1", {30'b0, st3}, {30'b0, S_WAIT});
        cyc(); sync_reset = 1'b1; #1;                               // T+2
        cyc(); #1;                                                  // T+3
        chk("t6_state", {30'b0, st3}, {30'b0, S_IDLE});
        chk("t6_re", {31'b0, re3}, 32'h0);
        chk("t6_saddr", {2'b0, saddr3}, 32'h0);
        chk("t6_busy", {31'b0, busy3}, 32'h0);
        chk("t6_done_T3", {31'b0, done3}, 32'h0);
        chk("t6_data", data3, 32'h0);
        chk("t6_mis", {31'b0, mis3}, 32'h0);
        cyc(); #1;                                                  // T+4
        chk("t6_done_T4", {31'b0, done3}, 32'h0);
        cyc(); #1;                                                  // T+5
        chk("t6_done_T5", {31'b0, done3}, 32'h0);
        cyc(); en3 = 1'b1; addr3 = 32'h4; #1;                      // U
        chk("t6_re_new", {31'b0, re3}, 32'h1);
        chk("t6_saddr_new", {2'b0, saddr3}, 32'h1);
        cyc(); #1;
        cyc(); #1;
        cyc(); #1;                                                  // U+3
        chk("t6_done_U3", {31'b0, done3}, 32'h0);
        cyc(); #1;                                                  // U+4
        chk("t6_done_U4", {31'b0, done3}, 32'h1);
        chk("t6_data_U4", data3, 32'h8000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
